// File: rtl/result_ser_pkg.sv
// Shared definitions for the result serializer: word-count helper, FSM states
// and the drop counter width.
package result_ser_pkg;

    // Width of the saturating dropped-sample counter.
    localparam int unsigned DROP_CNT_W = 8;

    // Serializer states: nothing to send, or streaming the head snapshot.
    typedef enum logic [0:0] {
        IDLE,
        SEND
    } ser_state_e;

    // Integer ceiling division, used to size the number of output words.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/snap_fifo.sv
// Register-based snapshot FIFO. DEPTH must be a power of two so the pointers
// wrap naturally. A push while full is accepted when a pop happens in the same
// cycle: the write lands in the slot the pop is vacating.
module snap_fifo #(
    parameter int unsigned DATA_W = 100,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // Full is only an obstacle if the head is not leaving this cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage array; written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/result_serializer.sv
// Snapshots the wide accumulator result on y_valid, buffers up to DEPTH
// snapshots and streams each one LSW-first as NWORDS words over valid/ready.
// Samples arriving while the buffer is full (and not draining) are dropped
// and counted.
module result_serializer
    import result_ser_pkg::*;
#(
    parameter int unsigned DATA_W = 100,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  y_valid,
    input  logic [DATA_W-1:0]     y,
    output logic [WORD_W-1:0]     o_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic                  o_last,
    output logic                  busy,
    output logic                  overrun,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned NWORDS = ceil_div(DATA_W, WORD_W);
    localparam int unsigned WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned PAD_W  = NWORDS * WORD_W;
    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(NWORDS - 1);

    ser_state_e            r_state;
    ser_state_e            w_state_nxt;
    logic [WIDX_W-1:0]     r_widx;
    logic [WIDX_W-1:0]     w_widx_nxt;
    logic                  r_overrun;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_sending;
    logic                  w_hs;
    logic                  w_at_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [DATA_W-1:0]     w_head;
    logic [PAD_W-1:0]      w_padded;
    logic [WORD_W-1:0]     w_word;

    assign w_sending = (r_state == SEND);
    assign w_hs      = w_sending && o_ready;
    assign w_at_last = (r_widx == LAST_WIDX);
    // The head leaves only once its final word has been accepted.
    assign w_pop     = w_hs && w_at_last;
    assign w_push    = y_valid && (!w_full || w_pop);
    assign w_drop    = y_valid && w_full && !w_pop;

    snap_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_snap_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (y),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // FSM state and word index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_widx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_widx  <= w_widx_nxt;
        end
    end

    // Next-state logic. Leaving IDLE on the push itself (not on the registered
    // non-empty flag) gives word 0 in the cycle right after the push edge.
    always_comb begin
        w_state_nxt = r_state;
        w_widx_nxt  = r_widx;
        unique case (r_state)
            IDLE: begin
                if (w_push || !w_empty) begin
                    w_state_nxt = SEND;
                    w_widx_nxt  = '0;
                end
            end
            SEND: begin
                if (w_hs) begin
                    if (!w_at_last) begin
                        w_widx_nxt = r_widx + WIDX_W'(1);
                    end else begin
                        w_widx_nxt = '0;
                        // Another entry remains after the pop, or arrives now.
                        if ((w_count > CNT_W'(1)) || w_push) begin
                            w_state_nxt = SEND;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_widx_nxt  = '0;
            end
        endcase
    end

    // Zero-extend the head entry to a whole number of words.
    always_comb begin
        w_padded               = '0;
        w_padded[DATA_W-1:0]   = w_head;
    end

    assign w_word = w_padded[int'(r_widx) * WORD_W +: WORD_W];

    // Sticky overrun flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Outputs depend only on registered state, so they are stable under stall
    // and clear immediately on reset.
    assign o_valid  = w_sending;
    assign o_data   = w_sending ? w_word : '0;
    assign o_last   = w_sending && w_at_last;
    assign busy     = w_sending || !w_empty;
    assign overrun  = r_overrun;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer at default parameters.
module tb_result_serializer;

    logic         clk;
    logic         rst;
    logic         y_valid;
    logic [99:0]  y;
    logic [31:0]  o_data;
    logic         o_valid;
    logic         o_ready;
    logic         o_last;
    logic         busy;
    logic         overrun;
    logic [7:0]   drop_cnt;

    int n_vec;
    int n_err;

    localparam logic [99:0] Y1 = 100'hA_89ABCDEF_01234567_DEADBEEF;

    result_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .y_valid  (y_valid),
        .y        (y),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_last   (o_last),
        .busy     (busy),
        .overrun  (overrun),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Distinct sample per index: top nibble, then three tagged words.
    function automatic logic [99:0] mk(input int i);
        logic [99:0] v;
        v = {4'(i), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
        return v;
    endfunction

    function automatic logic [31:0] wexp(input logic [99:0] v, input int k);
        logic [127:0] p;
        p = {28'b0, v};
        return p[k*32 +: 32];
    endfunction

    // Expects a full snapshot with o_ready held high, one word per cycle.
    task automatic stream_expect(input logic [99:0] v, input string tag);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_valid"}, 32'(o_valid), 32'd1);
            check({tag, "_data"}, o_data, wexp(v, k));
            check({tag, "_last"}, 32'(o_last), 32'(k == 3));
            tick();
        end
    endtask

    initial begin
        int idx;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        y_valid = 1'b0;
        y       = '0;
        o_ready = 1'b0;
        repeat (2) tick();

        // Reset values
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b1;
        tick();
        check("idle_valid", 32'(o_valid), 32'd0);

        // Single sample, ready high
        y       = Y1;
        y_valid = 1'b1;
        o_ready = 1'b1;
        tick();
        y_valid = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_w0", o_data, 32'hDEADBEEF);
        check("t1_l0", 32'(o_last), 32'd0);
        tick();
        check("t1_w1", o_data, 32'h01234567);
        tick();
        check("t1_w2", o_data, 32'h89ABCDEF);
        check("t1_l2", 32'(o_last), 32'd0);
        tick();
        check("t1_w3", o_data, 32'h0000000A);
        check("t1_l3", 32'(o_last), 32'd1);
        check("t1_v3", 32'(o_valid), 32'd1);
        tick();
        check("t1_end_valid", 32'(o_valid), 32'd0);
        check("t1_end_busy", 32'(busy), 32'd0);

        // Back-pressure: ready 1,0,0 repeating
        o_ready = 1'b0;
        y       = Y1;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            o_ready = (c % 3 == 0);
            check("t2_valid", 32'(o_valid), 32'd1);
            check("t2_data", o_data, wexp(Y1, idx));
            check("t2_last", 32'(o_last), 32'(idx == 3));
            tick();
            if (o_ready) idx++;
        end
        check("t2_count", 32'(idx), 32'd4);
        check("t2_end_valid", 32'(o_valid), 32'd0);

        // Overrun: 10 back-to-back samples with ready low
        o_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            y       = mk(i);
            y_valid = 1'b1;
            tick();
        end
        y_valid = 1'b0;
        check("t3_drop", 32'(drop_cnt), 32'd8);
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        tick();
        check("t3_hold_data", o_data, wexp(mk(0), 0));
        o_ready = 1'b1;
        stream_expect(mk(0), "t3_s0");
        stream_expect(mk(1), "t3_s1");
        for (int i = 0; i < 3; i++) begin
            check("t3_after_valid", 32'(o_valid), 32'd0);
            tick();
        end
        check("t3_after_busy", 32'(busy), 32'd0);

        // Push coinciding with last-word pop while full
        o_ready = 1'b0;
        y       = mk(20);
        y_valid = 1'b1;
        tick();
        y       = mk(21);
        tick();
        y_valid = 1'b0;
        o_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("t4_s20_data", o_data, wexp(mk(20), k));
            tick();
        end
        check("t4_s20_last", 32'(o_last), 32'd1);
        check("t4_s20_w3", o_data, wexp(mk(20), 3));
        y       = mk(22);
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        check("t4_drop", 32'(drop_cnt), 32'd8);
        stream_expect(mk(21), "t4_s21");
        stream_expect(mk(22), "t4_s22");
        check("t4_end_valid", 32'(o_valid), 32'd0);
        check("t4_end_busy", 32'(busy), 32'd0);

        // Reset in the middle of a two-snapshot backlog
        o_ready = 1'b0;
        y       = mk(30);
        y_valid = 1'b1;
        tick();
        y       = mk(31);
        tick();
        y_valid = 1'b0;
        o_ready = 1'b1;
        check("t5_w0", o_data, wexp(mk(30), 0));
        tick();
        check("t5_w1", o_data, wexp(mk(30), 1));
        tick();
        rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_data", o_data, 32'd0);
        check("t5_rst_last", 32'(o_last), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_overrun", 32'(overrun), 32'd0);
        check("t5_rst_drop", 32'(drop_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t5_quiet_valid", 32'(o_valid), 32'd0);
            check("t5_quiet_busy", 32'(busy), 32'd0);
            tick();
        end
        y       = mk(40);
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        stream_expect(mk(40), "t5_s40");
        check("t5_end_valid", 32'(o_valid), 32'd0);

        // Saturation: fill two entries then 300 drops
        o_ready = 1'b0;
        for (int i = 1; i <= 302; i++) begin
            y       = mk(i % 16);
            y_valid = 1'b1;
            tick();
            if (i == 256) check("t6_drop254", 32'(drop_cnt), 32'd254);
            if (i == 257) check("t6_drop255", 32'(drop_cnt), 32'd255);
        end
        y_valid = 1'b0;
        check("t6_drop_sat", 32'(drop_cnt), 32'd255);
        check("t6_overrun", 32'(overrun), 32'd1);
        o_ready = 1'b1;
        stream_expect(mk(1), "t6_s1");
        stream_expect(mk(2), "t6_s2");
        check("t6_end_busy", 32'(busy), 32'd0);
        check("t6_end_overrun", 32'(overrun), 32'd1);
        check("t6_end_drop", 32'(drop_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
